keyboard_scanner: RTL and testbench

KEYBOARD_SCANNER -- requirements
Module: keyboard_scanner

---
 rtl/keyboard_scanner.sv | 112 +++++++++++
 tb/tb_keyboard_scanner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_scanner.sv
// keyboard_scanner: column-strobed matrix keypad scanner with per-frame debounce and key encoding.
// Defining KEYB_REPEAT_EN adds auto-repeat of Key_Valid every REPEAT_FRAMES frames.
module keyboard_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_FRAMES = 64,
  localparam int CODE_W = $clog2(ROWS * COLS + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ROWS-1:0]   Keyb_Row_I,
  output logic [COLS-1:0]   Keyb_Col_O,
  output logic [CODE_W-1:0] Keyb_Value,
  output logic              Key_Valid,
  output logic              Key_Held,
  output logic              Key_Multi
);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8 || SCAN_DIV < 4 || SCAN_DIV > 255 ||
      DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_FRAMES < 2 || REPEAT_FRAMES > 1023) begin : g_bad_param
    $error("keyboard_scanner: parameter out of legal range");
  end

  logic [ROWS-1:0]   row_m, row_s;
  logic [CW-1:0]     col;
  logic [7:0]        div;
  logic [CODE_W-1:0] acc_code, samp_code, cur_code, cand;
  logic [1:0]        acc_n, samp_n, cur_n;
  logic [3:0]        stab;
  logic              last, frame_end, load;

  assign last       = div == 8'(SCAN_DIV - 1);
  assign frame_end  = last && col == CW'(COLS - 1);
  assign load       = stab == DB && cand != Keyb_Value;
  assign Key_Held   = Keyb_Value != '0;
  assign Keyb_Col_O = COLS'(1) << col;

  // Descending loop so the lowest pressed row in this column wins the code
  always_comb begin
    samp_code = '0;
    samp_n = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (row_s[r]) begin
        samp_code = CODE_W'(int'(col) * ROWS + r + 1);
        samp_n = samp_n == 2'd2 ? 2'd2 : samp_n + 2'd1;
      end
    cur_code = acc_code != '0 ? acc_code : samp_code;
    cur_n = ({1'b0, acc_n} + {1'b0, samp_n} >= 3'd2) ? 2'd2 : acc_n + samp_n;
  end

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      row_m      <= '0;
      row_s      <= '0;
      col        <= '0;
      div        <= '0;
      acc_code   <= '0;
      acc_n      <= '0;
      cand       <= '0;
      stab       <= '0;
      Keyb_Value <= '0;
      Key_Multi  <= 1'b0;
    end else begin
      row_m <= Keyb_Row_I;
      row_s <= row_m;
      div   <= last ? '0 : div + 8'd1;
      if (last) begin
        col      <= frame_end ? '0 : col + CW'(1);
        acc_code <= frame_end ? '0 : cur_code;
        acc_n    <= frame_end ? '0 : cur_n;
      end
      if (frame_end) begin
        Key_Multi <= cur_n == 2'd2;
        cand      <= cur_code;
        stab      <= cur_code == cand ? (stab == DB ? DB : stab + 4'd1) : 4'd1;
      end
      if (load)
        Keyb_Value <= cand;
    end

`ifdef KEYB_REPEAT_EN
  logic [9:0] rep;
  logic       tick;
  // tick trails frame end by one clock so repeats land on whole-frame multiples of the load
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      tick      <= 1'b0;
      rep       <= '0;
      Key_Valid <= 1'b0;
    end else begin
      tick      <= frame_end;
      Key_Valid <= 1'b0;
      if (load) begin
        rep       <= '0;
        Key_Valid <= cand != '0;
      end else if (tick && Key_Held) begin
        rep       <= rep == 10'(REPEAT_FRAMES - 1) ? '0 : rep + 10'd1;
        Key_Valid <= rep == 10'(REPEAT_FRAMES - 1);
      end
    end
`else
  always_ff @(posedge Clock or posedge Reset)
    if (Reset)
      Key_Valid <= 1'b0;
    else
      Key_Valid <= load && cand != '0;
`endif
endmodule

// File: tb/tb_keyboard_scanner.sv
// tb_keyboard_scanner: keypad-matrix stimulus against a frame-level reference model of the scanner.
module tb_keyboard_scanner;
  localparam int R = 4, C = 4, SD = 4, DB = 3, RF = 64, FR = C * SD, CW = 5;
`ifdef KEYB_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          Clock = 1'b0, Reset = 1'b1;
  logic [R-1:0]  Keyb_Row_I;
  logic [C-1:0]  Keyb_Col_O;
  logic [CW-1:0] Keyb_Value;
  logic          Key_Valid, Key_Held, Key_Multi;
  logic [R*C-1:0] keys = '0;
  int n_cmp = 0, n_bad = 0, dut_pulses = 0, mod_pulses = 0;

  int k = 0, mcol = 0, fc = 0, fn = 0, acc_at = -1, acc_code = 0, acc_k = 0, m_value = 0;
  bit m_valid = 0, m_multi = 0, same;
  logic [R-1:0] in1 = '0, in2 = '0, rs;
  int frames[$];

  keyboard_scanner #(.ROWS(R), .COLS(C), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_FRAMES(RF)) dut (
    .Clock(Clock), .Reset(Reset), .Keyb_Row_I(Keyb_Row_I), .Keyb_Col_O(Keyb_Col_O),
    .Keyb_Value(Keyb_Value), .Key_Valid(Key_Valid), .Key_Held(Key_Held), .Key_Multi(Key_Multi));

  always #5 Clock = ~Clock;

  // Physical keypad: a pressed key connects its column drive to its row line
  always_comb begin
    Keyb_Row_I = '0;
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++)
        if (keys[c*R+r] && Keyb_Col_O[c]) Keyb_Row_I[r] = 1'b1;
  end

  function automatic logic [R-1:0] rows_at(int cc);
    logic [R-1:0] v = '0;
    for (int r = 0; r < R; r++) v[r] = keys[cc*R+r];
    return v;
  endfunction

  // Reference: edge k since reset drives column (k/SD)%C; a frame's code is accepted
  // one clock after DB consecutive identical frame codes that differ from the current value.
  initial forever begin
    @(posedge Clock or posedge Reset);
    if (Reset) begin
      k = 0; mcol = 0; fc = 0; fn = 0; acc_at = -1; acc_code = 0; acc_k = 0;
      m_value = 0; m_valid = 0; m_multi = 0; in1 = '0; in2 = '0; frames.delete();
    end else begin
      rs = in2; in2 = in1; in1 = rows_at((k / SD) % C);
      m_valid = 0;
      if (k == acc_at) begin
        m_value = acc_code; m_valid = acc_code != 0; acc_k = k; acc_at = -1;
      end else if (REP && m_value != 0 && (k - acc_k) % (RF * FR) == 0) m_valid = 1;
      if (k % SD == SD - 1)
        for (int r = 0; r < R; r++)
          if (rs[r]) begin
            if (fc == 0) fc = ((k / SD) % C) * R + r + 1;
            fn++;
          end
      if (k % FR == FR - 1) begin
        m_multi = fn >= 2;
        frames.push_back(fc);
        if (frames.size() > DB) void'(frames.pop_front());
        same = frames.size() == DB;
        foreach (frames[i]) if (frames[i] != frames[0]) same = 0;
        if (same && frames[0] != m_value) begin acc_at = k + 1; acc_code = frames[0]; end
        fc = 0; fn = 0;
      end
      k++; mcol = (k / SD) % C;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge Clock);
      dut_pulses += int'(Key_Valid === 1'b1);
      mod_pulses += int'(m_valid);
    end
  endtask

  task automatic restart(logic [R*C-1:0] kv);
    Reset = 1'b1; keys = kv; step(2);
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; keys = '0; step(3);
    n_cmp++; if (Keyb_Col_O !== 4'b0001) begin n_bad++; $display("FAIL reset_col got %b exp 0001", Keyb_Col_O); end
    n_cmp++; if (Keyb_Value !== '0) begin n_bad++; $display("FAIL reset_value got %0d exp 0", Keyb_Value); end
    n_cmp++; if (Key_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", Key_Valid); end
    n_cmp++; if (Key_Held !== 1'b0) begin n_bad++; $display("FAIL reset_held got %b exp 0", Key_Held); end
    n_cmp++; if (Key_Multi !== 1'b0) begin n_bad++; $display("FAIL reset_multi got %b exp 0", Key_Multi); end
    Reset = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      step(1);
      n_cmp++; if (Keyb_Col_O !== C'(1 << mcol)) begin n_bad++; $display("FAIL col_walk got %b exp %b", Keyb_Col_O, C'(1 << mcol)); end
    end
  endtask

  task automatic test_clean_press;
    int lat = 0, p0;
    restart('0); step(5);
    p0 = dut_pulses;
    keys = 16'h0200;
    while (Key_Valid !== 1'b1 && lat < 100) begin step(1); lat++; end
    n_cmp++; if (lat > 67) begin n_bad++; $display("FAIL press_latency got %0d exp <=67", lat); end
    n_cmp++; if (Keyb_Value !== 5'd10) begin n_bad++; $display("FAIL press_value got %0d exp 10", Keyb_Value); end
    n_cmp++; if (Key_Held !== 1'b1) begin n_bad++; $display("FAIL press_held got %b exp 1", Key_Held); end
    step(10 * FR - lat);
    n_cmp++; if (dut_pulses - p0 != 1) begin n_bad++; $display("FAIL press_pulses got %0d exp 1", dut_pulses - p0); end
  endtask

  task automatic test_bounce;
    int p0;
    restart('0);
    p0 = dut_pulses;
    for (int i = 0; i < 8; i++) begin keys = i % 2 == 0 ? 16'h0010 : 16'h0000; step(5); end
    n_cmp++; if (dut_pulses != p0) begin n_bad++; $display("FAIL bounce_quiet got %0d exp 0", dut_pulses - p0); end
    keys = 16'h0010; step(6 * FR);
    n_cmp++; if (dut_pulses - p0 != 1) begin n_bad++; $display("FAIL bounce_pulses got %0d exp 1", dut_pulses - p0); end
    n_cmp++; if (Keyb_Value !== 5'd5) begin n_bad++; $display("FAIL bounce_value got %0d exp 5", Keyb_Value); end
  endtask

  task automatic test_multi;
    int p0 = dut_pulses;
    restart(16'h8001); step(2 * FR);
    n_cmp++; if (Key_Multi !== 1'b1) begin n_bad++; $display("FAIL multi_flag got %b exp 1", Key_Multi); end
    step(3 * FR);
    n_cmp++; if (Keyb_Value !== 5'd1) begin n_bad++; $display("FAIL multi_value got %0d exp 1", Keyb_Value); end
    n_cmp++; if (dut_pulses - p0 != 1) begin n_bad++; $display("FAIL multi_pulses got %0d exp 1", dut_pulses - p0); end
  endtask

  task automatic test_release;
    int p0;
    restart(16'h0200); step(5 * FR);
    p0 = dut_pulses;
    keys = '0; step(4 * FR + 8);
    n_cmp++; if (Keyb_Value !== '0) begin n_bad++; $display("FAIL release_value got %0d exp 0", Keyb_Value); end
    n_cmp++; if (Key_Held !== 1'b0) begin n_bad++; $display("FAIL release_held got %b exp 0", Key_Held); end
    n_cmp++; if (dut_pulses != p0) begin n_bad++; $display("FAIL release_pulses got %0d exp 0", dut_pulses - p0); end
  endtask

  task automatic test_reset_mid;
    int p0;
    restart(16'h0040); step(5 * FR + 7);
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if (Keyb_Col_O !== 4'b0001) begin n_bad++; $display("FAIL midrst_col got %b exp 0001", Keyb_Col_O); end
    n_cmp++; if (Keyb_Value !== '0 || Key_Held !== 1'b0) begin n_bad++; $display("FAIL midrst_value got %0d/%b exp 0/0", Keyb_Value, Key_Held); end
    n_cmp++; if (Key_Valid !== 1'b0 || Key_Multi !== 1'b0) begin n_bad++; $display("FAIL midrst_flags got %b/%b exp 0/0", Key_Valid, Key_Multi); end
    @(negedge Clock); Reset = 1'b0;
    p0 = dut_pulses;
    step(3 * FR + 20);
    n_cmp++; if (dut_pulses - p0 != 1) begin n_bad++; $display("FAIL midrst_pulses got %0d exp 1", dut_pulses - p0); end
    n_cmp++; if (Keyb_Value !== 5'd7) begin n_bad++; $display("FAIL midrst_value2 got %0d exp 7", Keyb_Value); end
  endtask

  task automatic test_back_to_back;
    int p0 = dut_pulses, q0 = mod_pulses;
    restart(16'h0200); step(5 * FR);
    keys = 16'h0002; step(5 * FR);
    n_cmp++; if (Keyb_Value !== 5'd2) begin n_bad++; $display("FAIL b2b_value got %0d exp 2", Keyb_Value); end
    n_cmp++; if (dut_pulses - p0 != 2) begin n_bad++; $display("FAIL b2b_pulses got %0d exp 2", dut_pulses - p0); end
    n_cmp++; if (dut_pulses - p0 != mod_pulses - q0) begin n_bad++; $display("FAIL b2b_model got %0d exp %0d", dut_pulses - p0, mod_pulses - q0); end
  endtask

  task automatic test_long_hold;
    int p0 = dut_pulses, q0 = mod_pulses;
    restart('0); step(3);
    keys = 16'h0200; step(200 * FR);
    n_cmp++; if (dut_pulses - p0 != (REP ? 4 : 1)) begin n_bad++; $display("FAIL hold_pulses got %0d exp %0d", dut_pulses - p0, REP ? 4 : 1); end
    n_cmp++; if (dut_pulses - p0 != mod_pulses - q0) begin n_bad++; $display("FAIL hold_model got %0d exp %0d", dut_pulses - p0, mod_pulses - q0); end
  endtask

  task automatic test_random;
    restart('0);
    for (int e = 0; e < 24; e++) begin
      keys = '0;
      for (int j = $urandom_range(0, 2); j > 0; j--) keys[$urandom_range(0, R * C - 1)] = 1'b1;
      for (int t = $urandom_range(8, 90); t > 0; t--) begin
        step(1);
        n_cmp++; if (Keyb_Value !== CW'(m_value)) begin n_bad++; if (n_bad < 30) $display("FAIL rnd_value got %0d exp %0d", Keyb_Value, m_value); end
        n_cmp++; if (Key_Valid !== m_valid) begin n_bad++; if (n_bad < 30) $display("FAIL rnd_valid got %b exp %b", Key_Valid, m_valid); end
        n_cmp++; if (Key_Held !== (m_value != 0)) begin n_bad++; if (n_bad < 30) $display("FAIL rnd_held got %b exp %b", Key_Held, m_value != 0); end
        n_cmp++; if (Key_Multi !== m_multi) begin n_bad++; if (n_bad < 30) $display("FAIL rnd_multi got %b exp %b", Key_Multi, m_multi); end
        n_cmp++; if (Keyb_Col_O !== C'(1 << mcol)) begin n_bad++; if (n_bad < 30) $display("FAIL rnd_col got %b exp %b", Keyb_Col_O, C'(1 << mcol)); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_multi;
    test_release;
    test_reset_mid;
    test_back_to_back;
    test_long_hold;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
